// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer pipeline stage with flush, back-pressure stall counter and flush drop counter.
// in_ready, out_valid and occupancy are flops loaded from the next state, so in_ready never sees out_ready combinationally.
module pipe_skid_reg #(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_main;
  logic [N-1:0]     r_skid;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:0]       r_occupancy;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_load_main;
  logic             w_main_from_skid;
  logic             w_load_skid;
  logic [1:0]       w_drop_inc;
  logic             w_stall_inc;
  logic [1:0]       w_occ_nxt;
  logic [CNT_W:0]   w_stall_sum;
  logic [CNT_W:0]   w_drop_sum;
  logic [CNT_W-1:0] w_stall_nxt;
  logic [CNT_W-1:0] w_drop_nxt;

  assign w_in_xfer   = in_valid & r_in_ready;
  assign w_out_xfer  = r_out_valid & out_ready;
  assign w_stall_inc = r_out_valid & ~out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, register load enables and flush drop amount
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_drop_inc       = 2'd0;
    if (flush) begin
      w_state_nxt = EMPTY;
      case (r_state)
        ONE:     w_drop_inc = w_out_xfer ? 2'd0 : 2'd1;
        FULL:    w_drop_inc = w_out_xfer ? 2'd1 : 2'd2;
        default: w_drop_inc = 2'd0;
      endcase
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_load_main = 1'b1;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          case ({w_in_xfer, w_out_xfer})
            2'b11: w_load_main = 1'b1;
            2'b01: w_state_nxt = EMPTY;
            2'b10: begin
              w_load_skid = 1'b1;
              w_state_nxt = FULL;
            end
            default: w_state_nxt = ONE;
          endcase
        end
        FULL: begin
          if (w_out_xfer) begin
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = ONE;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    case (w_state_nxt)
      ONE:     w_occ_nxt = 2'd1;
      FULL:    w_occ_nxt = 2'd2;
      default: w_occ_nxt = 2'd0;
    endcase
  end

  // Handshake and occupancy flops track the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occupancy <= 2'd0;
    end else begin
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
      r_occupancy <= w_occ_nxt;
    end
  end

  // Payload registers; main keeps its value while the stage is empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main) begin
        r_main <= w_main_from_skid ? r_skid : in_data;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

  // Saturating counters: a carry out of the widened sum pins the count at all-ones
  assign w_stall_sum = {1'b0, r_stall_cnt} + (CNT_W+1)'(w_stall_inc);
  assign w_drop_sum  = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop_inc);
  assign w_stall_nxt = w_stall_sum[CNT_W] ? {CNT_W{1'b1}} : w_stall_sum[CNT_W-1:0];
  assign w_drop_nxt  = w_drop_sum[CNT_W]  ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_stall_cnt <= w_stall_nxt;
      r_drop_cnt  <= w_drop_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign occupancy = r_occupancy;
  assign stall_cnt = r_stall_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule
